// File: rtl/sap_1_opcode_sequencer_pkg.sv
// sap_1_opcode_sequencer_pkg: shared opcodes, control-word bit masks and T-state one-hot constants
// Contents:
//   opcode_e       - SAP-1 opcode encodings (all unlisted values execute as NOP)
//   C_*            - single-bit masks into the 12-bit control word con
//   T1..T6         - one-hot ring-counter states, bit0 = T1
//   is_onehot6()   - legality test for a ring-counter value
package sap_1_opcode_sequencer_pkg;
    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;
    localparam logic [11:0] C_CP = 12'h800;
    localparam logic [11:0] C_EP = 12'h400;
    localparam logic [11:0] C_LM = 12'h200;
    localparam logic [11:0] C_CE = 12'h100;
    localparam logic [11:0] C_LI = 12'h080;
    localparam logic [11:0] C_EI = 12'h040;
    localparam logic [11:0] C_LA = 12'h020;
    localparam logic [11:0] C_EA = 12'h010;
    localparam logic [11:0] C_SU = 12'h008;
    localparam logic [11:0] C_EU = 12'h004;
    localparam logic [11:0] C_LB = 12'h002;
    localparam logic [11:0] C_LO = 12'h001;
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;
    function automatic logic is_onehot6(input logic [5:0] v);
        return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
    endfunction
endpackage

// File: rtl/sap_1_opcode_sequencer_ring_counter.sv
// sap_1_opcode_sequencer_ring_counter: six-position one-hot T-state ring with early wrap and self-repair
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset, forces T1
//   advance    - step the ring one position on this edge
//   early_wrap - when advancing, load T1 instead of the next position
//   t_state    - one-hot state, bit0 = T1 ... bit5 = T6
module sap_1_opcode_sequencer_ring_counter
    import sap_1_opcode_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    input  logic       early_wrap,
    output logic [5:0] t_state
);
    // An illegal (zero or multi-hot) value is repaired even while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            t_state <= T1;
        else if (!is_onehot6(t_state))
            t_state <= T1;
        else if (advance)
            t_state <= early_wrap ? T1 : {t_state[4:0], t_state[5]};
    end
endmodule

// File: rtl/sap_1_opcode_sequencer.sv
// sap_1_opcode_sequencer: SAP-1 T-state sequencer, opcode decode and control-word generation
// Ports:
//   clk         - system clock, rising edge
//   rst_n       - asynchronous active-low reset
//   run         - advance enable; low stalls in the current T-state
//   opcode      - instruction-register upper nibble
//   t_state     - one-hot T-state, bit0 = T1 ... bit5 = T6
//   inst_onehot - decoded opcode one-hot during T4..T6, else zero
//   con         - control word [11]Cp [10]Ep [9]Lm [8]CE [7]Li [6]Ei [5]La [4]Ea [3]Su [2]Eu [1]Lb [0]Lo
//   halted      - registered halt flag, cleared only by rst_n
// Build option:
//   SAP_1_EARLY_FETCH_EN - OUT/NOP return to T1 after T4, LDA after T5; ADD/SUB keep six states
module sap_1_opcode_sequencer
    import sap_1_opcode_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [3:0]  opcode,
    output logic [5:0]  t_state,
    output logic [15:0] inst_onehot,
    output logic [11:0] con,
    output logic        halted
);
    logic        is_lda, is_add, is_sub, is_out, is_hlt;
    logic        active, halt_now, early_wrap;
    logic [11:0] con_raw;
    assign is_lda = opcode == OP_LDA;
    assign is_add = opcode == OP_ADD;
    assign is_sub = opcode == OP_SUB;
    assign is_out = opcode == OP_OUT;
    assign is_hlt = opcode == OP_HLT;
    // rst_n is included so no load strobe escapes while reset is held.
    assign active   = rst_n && run && !halted;
    assign halt_now = active && t_state == T4 && is_hlt;
`ifdef SAP_1_EARLY_FETCH_EN
    assign early_wrap = halt_now
                     || (t_state == T4 && !(is_lda || is_add || is_sub))
                     || (t_state == T5 && is_lda);
`else
    assign early_wrap = halt_now;
`endif
    sap_1_opcode_sequencer_ring_counter u_ring (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (run && !halted),
        .early_wrap (early_wrap),
        .t_state    (t_state)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            halted <= 1'b0;
        else if (halt_now)
            halted <= 1'b1;
    end
    always_comb begin
        con_raw = '0;
        case (t_state)
            T1: con_raw = C_EP | C_LM;
            T2: con_raw = C_CP;
            T3: con_raw = C_CE | C_LI;
            T4: con_raw = (is_lda || is_add || is_sub) ? (C_EI | C_LM) : is_out ? (C_EA | C_LO) : '0;
            T5: con_raw = is_lda ? (C_CE | C_LA) : (is_add || is_sub) ? (C_CE | C_LB) : '0;
            T6: con_raw = is_add ? (C_LA | C_EU) : is_sub ? (C_LA | C_SU | C_EU) : '0;
            default: con_raw = '0;
        endcase
    end
    assign con         = active ? con_raw : '0;
    assign inst_onehot = (active && (t_state == T4 || t_state == T5 || t_state == T6))
                         ? (16'h0001 << opcode) : 16'h0000;
endmodule

// File: tb/tb_sap_1_opcode_sequencer.sv
// tb_sap_1_opcode_sequencer: directed self-checking bench for sap_1_opcode_sequencer
module tb_sap_1_opcode_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [3:0]  opcode;
    logic [5:0]  t_state;
    logic [15:0] inst_onehot;
    logic [11:0] con;
    logic        halted;
    int          n_cmp = 0;
    int          n_err = 0;

    sap_1_opcode_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .opcode      (opcode),
        .t_state     (t_state),
        .inst_onehot (inst_onehot),
        .con         (con),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [5:0] t, input logic [11:0] c, input logic [15:0] oh);
        chk({tag, "_t"}, 32'(t_state), 32'(t));
        chk({tag, "_con"}, 32'(con), 32'(c));
        chk({tag, "_oh"}, 32'(inst_onehot), 32'(oh));
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; opcode = 4'h0;
        tick;
        chk_state("rst", 6'h01, 12'h000, 16'h0000);
        chk("rst_halted", 32'(halted), 32'd0);
        tick;
        run = 1'b1; rst_n = 1'b1; #1;
        // LDA, full six-state walk
        chk_state("lda_t1", 6'h01, 12'h600, 16'h0000);
        tick; chk_state("lda_t2", 6'h02, 12'h800, 16'h0000);
        tick; chk_state("lda_t3", 6'h04, 12'h180, 16'h0000);
        tick; chk_state("lda_t4", 6'h08, 12'h240, 16'h0001);
        tick; chk_state("lda_t5", 6'h10, 12'h120, 16'h0001);
        tick;
`ifdef SAP_1_EARLY_FETCH_EN
        chk_state("lda_wrap", 6'h01, 12'h600, 16'h0000);
`else
        chk_state("lda_t6", 6'h20, 12'h000, 16'h0001);
        tick; chk_state("lda_wrap", 6'h01, 12'h600, 16'h0000);
`endif
        // SUB
        opcode = 4'h2; #1;
        tick; tick; tick;
        chk_state("sub_t4", 6'h08, 12'h240, 16'h0004);
        tick; chk_state("sub_t5", 6'h10, 12'h102, 16'h0004);
        tick; chk_state("sub_t6", 6'h20, 12'h02C, 16'h0004);
        tick; chk_state("sub_wrap", 6'h01, 12'h600, 16'h0000);
        // stall in T3
        tick; tick;
        run = 1'b0; #1;
        chk_state("stall_t3", 6'h04, 12'h000, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("stall_hold_t", 32'(t_state), 32'h04);
        end
        chk("stall_con", 32'(con), 32'h000);
        run = 1'b1; #1;
        chk_state("resume_t3", 6'h04, 12'h180, 16'h0000);
        tick; chk_state("resume_t4", 6'h08, 12'h240, 16'h0004);
        // async reset between edges during T5
        tick; chk_state("pre_rst_t5", 6'h10, 12'h102, 16'h0004);
        #1 rst_n = 1'b0; #1;
        chk_state("mid_rst", 6'h01, 12'h000, 16'h0000);
        chk("mid_rst_halted", 32'(halted), 32'd0);
        #1 rst_n = 1'b1; #1;
        chk("mid_rst_rel_t", 32'(t_state), 32'h01);
        tick; chk("rst_rel_t2", 32'(t_state), 32'h02);
        tick; tick; tick; tick; tick;
        chk("sub2_wrap_t", 32'(t_state), 32'h01);
        // OUT
        opcode = 4'hE; #1;
        tick; tick; tick;
        chk_state("out_t4", 6'h08, 12'h011, 16'h4000);
        tick;
`ifdef SAP_1_EARLY_FETCH_EN
        chk_state("out_wrap", 6'h01, 12'h600, 16'h0000);
`else
        chk_state("out_t5", 6'h10, 12'h000, 16'h4000);
        tick; chk_state("out_t6", 6'h20, 12'h000, 16'h4000);
        tick; chk_state("out_wrap", 6'h01, 12'h600, 16'h0000);
`endif
        // ADD
        opcode = 4'h1; #1;
        tick; tick; tick;
        chk_state("add_t4", 6'h08, 12'h240, 16'h0002);
        tick; chk_state("add_t5", 6'h10, 12'h102, 16'h0002);
        tick; chk_state("add_t6", 6'h20, 12'h024, 16'h0002);
        tick; chk("add_wrap_t", 32'(t_state), 32'h01);
        // NOP (opcode 5)
        opcode = 4'h5; #1;
        tick; tick; tick;
        chk_state("nop_t4", 6'h08, 12'h000, 16'h0020);
        tick;
`ifdef SAP_1_EARLY_FETCH_EN
        chk("nop_wrap_t", 32'(t_state), 32'h01);
`else
        chk_state("nop_t5", 6'h10, 12'h000, 16'h0020);
        tick; chk_state("nop_t6", 6'h20, 12'h000, 16'h0020);
        tick; chk("nop_wrap_t", 32'(t_state), 32'h01);
`endif
        // HLT
        opcode = 4'hF; #1;
        tick; tick; tick;
        chk_state("hlt_t4", 6'h08, 12'h000, 16'h8000);
        chk("hlt_t4_halted", 32'(halted), 32'd0);
        tick;
        chk("hlt_halted", 32'(halted), 32'd1);
        chk_state("hlt_frozen", 6'h01, 12'h000, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            run = i[0]; opcode = 4'(i); #1;
            tick;
            chk("hlt_hold_t", 32'(t_state), 32'h01);
            chk("hlt_hold_con", 32'(con), 32'h000);
        end
        run = 1'b1; opcode = 4'h0; #1;
        chk_state("hlt_end", 6'h01, 12'h000, 16'h0000);
        chk("hlt_end_halted", 32'(halted), 32'd1);
        // only reset clears halt
        rst_n = 1'b0; #1;
        chk("unhalt_halted", 32'(halted), 32'd0);
        #1 rst_n = 1'b1; #1;
        chk("unhalt_con", 32'(con), 32'h600);
        tick; chk_state("unhalt_t2", 6'h02, 12'h800, 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
